// File: rtl/arm_alu_pkg.sv
// arm_alu_pkg: shared definitions for the ARM-style execute-stage ALU.
// Holds the data width, the 4-bit data-processing opcode encoding and a
// helper that tells the datapath whether an opcode uses the adder.
// Build option: define ALU_LOGIC_V_HOLD_EN to make logical ops keep the
// previous V flag instead of clearing it (see arm_alu.sv).
package arm_alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_EOR = 4'b0001,
    OP_SUB = 4'b0010,
    OP_RSB = 4'b0011,
    OP_ADD = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSC = 4'b0111,
    OP_TST = 4'b1000,
    OP_TEQ = 4'b1001,
    OP_CMP = 4'b1010,
    OP_CMN = 4'b1011,
    OP_ORR = 4'b1100,
    OP_MOV = 4'b1101,
    OP_BIC = 4'b1110,
    OP_MVN = 4'b1111
  } opcode_e;

  // True for opcodes whose result and C/V flags come from the adder.
  function automatic logic is_arith(input opcode_e op);
    logic arith;
    case (op)
      OP_SUB, OP_RSB, OP_ADD, OP_ADC,
      OP_SBC, OP_RSC, OP_CMP, OP_CMN: arith = 1'b1;
      default:                        arith = 1'b0;
    endcase
    return arith;
  endfunction

endpackage

// File: rtl/arm_alu_adder.sv
// arm_alu_adder: 33-bit adder computing x + y + cin.
// Operand inversion for subtraction is done by the caller, so the
// overflow flag here is simply "same-signed inputs, different-signed sum".
module arm_alu_adder
  import arm_alu_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              v
);

  logic [DATA_W:0] full;

  // Single wide add; the extra top bit is the ARM carry (no-borrow for subtracts).
  always_comb begin
    full = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, cin};
  end

  assign sum  = full[DATA_W-1:0];
  assign cout = full[DATA_W];
  assign v    = (x[DATA_W-1] == y[DATA_W-1]) && (full[DATA_W-1] != x[DATA_W-1]);

endmodule

// File: rtl/arm_alu.sv
// arm_alu: 32-bit ARM data-processing ALU with registered result and NZCV flags.
// Arithmetic ops share one adder whose operands are swapped/inverted here;
// logical ops pass CIN through as the C flag (shifter carry-out).
// Build option ALU_LOGIC_V_HOLD_EN: logical ops keep the previous V flag;
// without it they clear V. Reset always clears every output.
module arm_alu
  import arm_alu_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] IL,
  input  logic [DATA_W-1:0] IR,
  input  logic [3:0]        IF,
  input  logic              CIN,
  output logic [DATA_W-1:0] ALUOUT,
  output logic              ZERO,
  output logic              N,
  output logic              COUT,
  output logic              V
);

  opcode_e           op;
  logic [DATA_W-1:0] addx;
  logic [DATA_W-1:0] addy;
  logic              addcin;
  logic [DATA_W-1:0] sum;
  logic              addcout;
  logic              addv;
  logic [DATA_W-1:0] logicres;
  logic [DATA_W-1:0] result;
  logic              arith;

  assign op    = opcode_e'(IF);
  assign arith = is_arith(op);

  // Pick adder operands: reverse ops swap A/B, subtracts invert the subtrahend.
  always_comb begin
    addx   = IL;
    addy   = IR;
    addcin = 1'b0;
    case (op)
      OP_SUB, OP_CMP: begin
        addy   = ~IR;
        addcin = 1'b1;
      end
      OP_RSB: begin
        addx   = IR;
        addy   = ~IL;
        addcin = 1'b1;
      end
      OP_ADC: begin
        addcin = CIN;
      end
      OP_SBC: begin
        addy   = ~IR;
        addcin = CIN;
      end
      OP_RSC: begin
        addx   = IR;
        addy   = ~IL;
        addcin = CIN;
      end
      default: begin
      end
    endcase
  end

  arm_alu_adder u_adder (
    .x    (addx),
    .y    (addy),
    .cin  (addcin),
    .sum  (sum),
    .cout (addcout),
    .v    (addv)
  );

  // Bitwise result for the logical ops (test ops drive their value too).
  always_comb begin
    logicres = '0;
    case (op)
      OP_AND, OP_TST: logicres = IL & IR;
      OP_EOR, OP_TEQ: logicres = IL ^ IR;
      OP_ORR:         logicres = IL | IR;
      OP_MOV:         logicres = IR;
      OP_BIC:         logicres = IL & ~IR;
      OP_MVN:         logicres = ~IR;
      default:        logicres = '0;
    endcase
  end

  assign result = arith ? sum : logicres;

  // Output and flag registers; reset clears everything, including ZERO.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ALUOUT <= '0;
      ZERO   <= 1'b0;
      N      <= 1'b0;
      COUT   <= 1'b0;
      V      <= 1'b0;
    end else begin
      ALUOUT <= result;
      ZERO   <= (result == '0);
      N      <= result[DATA_W-1];
      COUT   <= arith ? addcout : CIN;
`ifdef ALU_LOGIC_V_HOLD_EN
      if (arith) begin
        V <= addv;
      end
`else
      V      <= arith ? addv : 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_arm_alu.sv
// tb_arm_alu: self-checking bench for arm_alu. Expected values come from a
// signed/unsigned integer model of the ARM data-processing rules.
module tb_arm_alu;

`ifdef ALU_LOGIC_V_HOLD_EN
  localparam logic VHOLD = 1'b1;
`else
  localparam logic VHOLD = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic [31:0] IL;
  logic [31:0] IR;
  logic [3:0]  IF;
  logic        CIN;
  logic [31:0] ALUOUT;
  logic        ZERO;
  logic        N;
  logic        COUT;
  logic        V;

  int   total;
  int   bad;
  logic lastV;

  arm_alu dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IL     (IL),
    .IR     (IR),
    .IF     (IF),
    .CIN    (CIN),
    .ALUOUT (ALUOUT),
    .ZERO   (ZERO),
    .N      (N),
    .COUT   (COUT),
    .V      (V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Reference model: returns {result, N, Z, C, V} using plain integer math.
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic prevV);
    longint ua, ub, sa, sb, u, s, ci, bw;
    logic [31:0] r;
    logic c, v, z, isSub, isArith;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    ci = cin ? 1 : 0;
    bw = cin ? 0 : 1;
    u = 0; s = 0; r = '0;
    isSub = 1'b0; isArith = 1'b1;
    case (op)
      4'h4, 4'hB: begin u = ua + ub;      s = sa + sb;      end
      4'h5:       begin u = ua + ub + ci; s = sa + sb + ci; end
      4'h2, 4'hA: begin u = ua - ub;      s = sa - sb;      isSub = 1'b1; end
      4'h6:       begin u = ua - ub - bw; s = sa - sb - bw; isSub = 1'b1; end
      4'h3:       begin u = ub - ua;      s = sb - sa;      isSub = 1'b1; end
      4'h7:       begin u = ub - ua - bw; s = sb - sa - bw; isSub = 1'b1; end
      4'h0, 4'h8: begin r = a & b;  isArith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  isArith = 1'b0; end
      4'hC:       begin r = a | b;  isArith = 1'b0; end
      4'hD:       begin r = b;      isArith = 1'b0; end
      4'hE:       begin r = a & ~b; isArith = 1'b0; end
      default:    begin r = ~b;     isArith = 1'b0; end
    endcase
    if (isArith) begin
      r = u[31:0];
      c = isSub ? (u >= 0) : (u >= 64'sh1_0000_0000);
      v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
    end else begin
      c = cin;
      v = VHOLD ? prevV : 1'b0;
    end
    z = (r == 32'h0);
    return {r, r[31], z, c, v};
  endfunction

  // Drive one operation and step to just after the capturing edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin);
    IF  = op;
    IL  = a;
    IR  = b;
    CIN = cin;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [35:0] exp;
    RST_N = 1'b0;
    applyStimulus(4'($urandom), $urandom, $urandom, 1'($urandom));
    applyStimulus(4'($urandom), $urandom, $urandom, 1'($urandom));
    total++;
    if (ALUOUT !== 32'h0) begin
      bad++;
      $display("[TB] FAIL reset_aluout: got %h want 00000000", ALUOUT);
    end
    total++;
    if ({N, ZERO, COUT, V} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags: got NZCV=%b want 0000", {N, ZERO, COUT, V});
    end
    lastV = 1'b0;
    RST_N = 1'b1;
    exp = model(4'h4, 32'd5, 32'd6, 1'b0, lastV);
    applyStimulus(4'h4, 32'd5, 32'd6, 1'b0);
    total++;
    if ({ALUOUT, N, ZERO, COUT, V} !== exp) begin
      bad++;
      $display("[TB] FAIL reset_first_op: got %h/%b want %h/%b",
               ALUOUT, {N, ZERO, COUT, V}, exp[35:4], exp[3:0]);
    end
    lastV = exp[0];
  endtask

  task automatic test_sweep();
    logic [31:0] table_res [16];
    logic [35:0] exp;
    table_res = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'h1, 32'h0, 32'h0, 32'h2, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFE};
    for (int i = 0; i < 16; i++) begin
      exp = model(4'(i), 32'h1, 32'h1, 1'b0, lastV);
      applyStimulus(4'(i), 32'h1, 32'h1, 1'b0);
      total++;
      if (ALUOUT !== table_res[i]) begin
        bad++;
        $display("[TB] FAIL sweep_result op=%0d: got %h want %h", i, ALUOUT, table_res[i]);
      end
      total++;
      if ({N, ZERO, COUT, V} !== exp[3:0]) begin
        bad++;
        $display("[TB] FAIL sweep_flags op=%0d: got NZCV=%b want %b", i, {N, ZERO, COUT, V}, exp[3:0]);
      end
      lastV = exp[0];
    end
  endtask

  task automatic test_corners();
    logic [3:0]  ops  [5];
    logic [31:0] as   [5];
    logic [31:0] bs   [5];
    logic        cins [5];
    logic [35:0] want [5];
    ops  = '{4'h5, 4'h4, 4'h4, 4'h2, 4'hC};
    as   = '{32'h1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hF0};
    bs   = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0F};
    cins = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    want = '{{32'h3, 4'b0000}, {32'h80000000, 4'b1001}, {32'h0, 4'b0110},
             {32'h7FFFFFFF, 4'b0011}, {32'hFF, 3'b001, VHOLD}};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(ops[i], as[i], bs[i], cins[i]);
      total++;
      if ({ALUOUT, N, ZERO, COUT, V} !== want[i]) begin
        bad++;
        $display("[TB] FAIL corner_%0d: got %h NZCV=%b want %h NZCV=%b",
                 i, ALUOUT, {N, ZERO, COUT, V}, want[i][35:4], want[i][3:0]);
      end
      lastV = want[i][0];
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [35:0] exp;
    for (int i = 0; i < 300; i++) begin
      op  = 4'($urandom);
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      cin = 1'($urandom);
      exp = model(op, a, b, cin, lastV);
      applyStimulus(op, a, b, cin);
      total++;
      if ({ALUOUT, N, ZERO, COUT, V} !== exp) begin
        bad++;
        $display("[TB] FAIL random op=%h a=%h b=%h cin=%b: got %h/%b want %h/%b",
                 op, a, b, cin, ALUOUT, {N, ZERO, COUT, V}, exp[35:4], exp[3:0]);
      end
      lastV = exp[0];
    end
  endtask

  task automatic test_hold_between_edges();
    logic [35:0] exp;
    exp = model(4'h4, 32'h12345678, 32'h11111111, 1'b0, lastV);
    applyStimulus(4'h4, 32'h12345678, 32'h11111111, 1'b0);
    IF = 4'hF; IL = 32'h0; IR = 32'h0; CIN = 1'b1;
    #3;
    total++;
    if ({ALUOUT, N, ZERO, COUT, V} !== exp) begin
      bad++;
      $display("[TB] FAIL hold_between_edges: got %h/%b want %h/%b",
               ALUOUT, {N, ZERO, COUT, V}, exp[35:4], exp[3:0]);
    end
    lastV = exp[0];
    @(posedge CLK);
    #1;
    lastV = VHOLD ? lastV : 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        cin;
    logic [35:0] exp;
    for (int i = 0; i < 10; i++) begin
      op  = 4'($urandom);
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      if (i == 5) begin
        RST_N = 1'b0;
        exp   = '0;
      end else begin
        RST_N = 1'b1;
        exp   = model(op, a, b, cin, lastV);
      end
      applyStimulus(op, a, b, cin);
      total++;
      if ({ALUOUT, N, ZERO, COUT, V} !== exp) begin
        bad++;
        $display("[TB] FAIL back_to_back step=%0d rst=%b: got %h/%b want %h/%b",
                 i, RST_N, ALUOUT, {N, ZERO, COUT, V}, exp[35:4], exp[3:0]);
      end
      lastV = exp[0];
    end
    RST_N = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lastV = 1'b0;
    RST_N = 1'b0;
    IL    = '0;
    IR    = '0;
    IF    = '0;
    CIN   = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_sweep();
    test_corners();
    test_random();
    test_hold_between_edges();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
